// File: rtl/v_issue_queue.sv
// -----------------------------------------------------------------------------
// v_issue_queue
//   Producer-side instruction queue for the vector coprocessor. The scalar core
//   hands over vector instructions with their rs1/rs2 values. They are buffered
//   in a small FIFO and issued in order to the coprocessor decoder.
//   Vector-config instructions (OP_SET) are serialised against the vector
//   datapath:
//     - a config issues only while the datapath is idle;
//     - younger instructions stay blocked until the datapath is idle again.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
//   valid && ready. Valid never depends on ready. While m_valid && !m_ready,
//   m_instr/m_rs1/m_rs2 hold their values.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   flush            drop every queued entry (scalar-side trap)
//   s_valid/s_ready  producer handshake; s_instr, s_rs1, s_rs2 payload
//   m_valid/m_ready  decoder handshake; m_instr, m_rs1, m_rs2 = head entry
//   v_busy           vector datapath has instructions in flight
//   illegal          one-cycle pulse after a non-vector opcode was consumed
//   count            number of valid entries
// -----------------------------------------------------------------------------
module v_issue_queue #(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [31:0]   s_instr,
   input  logic [31:0]   s_rs1,
   input  logic [31:0]   s_rs2,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [31:0]   m_instr,
   output logic [31:0]   m_rs1,
   output logic [31:0]   m_rs2,
   input  logic          v_busy,
   output logic          illegal,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   // Opcode / funct3 encodings shared with v_decoder (instr[5:0], instr[14:12]).
   localparam logic [5:0] OPC_RTYPE = 6'h17;
   localparam logic [5:0] OPC_LTYPE = 6'h07;
   localparam logic [5:0] OPC_STYPE = 6'h27;
   localparam logic [2:0] OP_SET    = 3'b111;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // RUN  : head may issue.
   // DRAIN: a config is at the head and waits for the datapath to go idle.
   // CFG  : a config has just issued; younger entries wait for idle.
   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      CFG   = 2'd2
   } state_t;

   state_t state;

   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   rs1_mem   [DEPTH];
   logic [31:0]   rs2_mem   [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic s_vec;
   logic head_cfg;
   logic not_empty;
   logic push;
   logic push_vec;
   logic pop;

   function automatic logic is_vector(input logic [31:0] instr);
      return (instr[5:0] == OPC_RTYPE) || (instr[5:0] == OPC_LTYPE) ||
             (instr[5:0] == OPC_STYPE);
   endfunction

   always_comb begin
      s_vec     = is_vector(s_instr);
      not_empty = (count != '0);

      m_instr = instr_mem[rd_ptr];
      m_rs1   = rs1_mem[rd_ptr];
      m_rs2   = rs2_mem[rd_ptr];

      head_cfg = (m_instr[5:0] == OPC_RTYPE) && (m_instr[14:12] == OP_SET);

      // No bypass: the queue refuses when full, even if the head pops this cycle.
      s_ready = !rst && (count != FULL);

      // A config at the head may only go out while the datapath is idle.
      // Ordinary instructions ignore v_busy.
      m_valid = !rst && not_empty && (state == RUN) && (!head_cfg || !v_busy);

      push     = s_valid && s_ready;
      push_vec = push && s_vec;
      pop      = m_valid && m_ready;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         state   <= RUN;
         illegal <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            rs1_mem[i]   <= '0;
            rs2_mem[i]   <= '0;
         end
      end else begin
         // Non-vector words are consumed so the core does not stall.
         // They are reported here, also in a flush cycle.
         illegal <= push && !s_vec;

         if (flush) begin
            // Flush beats any push or pop of the same cycle.
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= RUN;
         end else begin
            if (push_vec) begin
               instr_mem[wr_ptr] <= s_instr;
               rs1_mem[wr_ptr]   <= s_rs1;
               rs2_mem[wr_ptr]   <= s_rs2;
               wr_ptr            <= wr_ptr + AW'(1);
            end

            if (pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end

            case ({push_vec, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase

            case (state)
               RUN: begin
                  if (not_empty && head_cfg) begin
                     if (v_busy) begin
                        state <= DRAIN;
                     end else if (pop) begin
                        state <= CFG;
                     end
                  end
               end
               DRAIN: begin
                  if (!v_busy) begin
                     state <= RUN;
                  end
               end
               CFG: begin
                  // This state is entered on the config's pop edge.
                  // The earliest exit is the following edge, so m_valid is low
                  // for at least one full cycle after a config issues.
                  if (!v_busy) begin
                     state <= RUN;
                  end
               end
               default: state <= RUN;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_v_issue_queue.sv
// -----------------------------------------------------------------------------
// tb_v_issue_queue
//   Bench for v_issue_queue (DEPTH=4).
//   - A negedge monitor keeps the expected issue order in exp_q. It also keeps
//     count and illegal against its own model.
//   - A classification table and hand-written sequences cover the FSM, full,
//     wrap, flush and reset cases.
// -----------------------------------------------------------------------------
module tb_v_issue_queue;

   localparam int DEPTH = 4;
   localparam int CW    = 3;

   localparam logic [5:0] OPC_RTYPE = 6'h17;
   localparam logic [5:0] OPC_LTYPE = 6'h07;
   localparam logic [5:0] OPC_STYPE = 6'h27;
   localparam logic [2:0] OP_SET    = 3'b111;
   localparam logic [2:0] OPI_VV    = 3'b000;
   localparam logic [2:0] W32       = 3'b110;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_CFG   = 2'd2;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [31:0]   s_instr = '0;
   logic [31:0]   s_rs1 = '0;
   logic [31:0]   s_rs2 = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [31:0]   m_instr;
   logic [31:0]   m_rs1;
   logic [31:0]   m_rs2;
   logic          v_busy = 1'b0;
   logic          illegal;
   logic [CW-1:0] count;

   always #5 clk = ~clk;

   v_issue_queue #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_instr (s_instr),
      .s_rs1   (s_rs1),
      .s_rs2   (s_rs2),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_instr (m_instr),
      .m_rs1   (m_rs1),
      .m_rs2   (m_rs2),
      .v_busy  (v_busy),
      .illegal (illegal),
      .count   (count)
   );

   // ---------------- helpers ----------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk(input logic [5:0] opc, input logic [2:0] f3,
                                      input logic [7:0] tag);
      return {tag, 9'd0, f3, 6'd0, opc};
   endfunction

   function automatic logic model_vec(input logic [31:0] instr);
      return (instr[5:0] == OPC_RTYPE) || (instr[5:0] == OPC_LTYPE) ||
             (instr[5:0] == OPC_STYPE);
   endfunction

   // ---------------- scoreboard / monitor ----------------
   logic [95:0] exp_q[$];
   logic        exp_ill = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         check("rst_s_ready", s_ready, 1'b0);
         check("rst_m_valid", m_valid, 1'b0);
         exp_q.delete();
         exp_ill = 1'b0;
      end else begin
         check("count_model", count, exp_q.size());
         check("illegal_model", illegal, exp_ill);
         if (exp_q.size() == 0) check("mvalid_empty", m_valid, 1'b0);
         exp_ill = s_valid && s_ready && !model_vec(s_instr);
         if (flush) begin
            exp_q.delete();
         end else begin
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  check("issue_unexpected", m_valid, 1'b0);
               end else begin
                  check("issue_data", {m_instr, m_rs1, m_rs2}, exp_q.pop_front());
               end
            end
            if (s_valid && s_ready && model_vec(s_instr))
               exp_q.push_back({s_instr, s_rs1, s_rs2});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer one word and hold it until accepted (bounded).
   // Returns #1 after the accepting edge.
   task automatic push_one(input logic [31:0] instr, input logic [31:0] rs1,
                           input logic [31:0] rs2);
      logic acc;
      int   n;
      s_valid = 1'b1;
      s_instr = instr;
      s_rs1   = rs1;
      s_rs2   = rs2;
      n       = 0;
      acc     = 1'b0;
      do begin
         @(negedge clk);
         acc = s_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      s_valid = 1'b0;
      check("push_accept", acc, 1'b1);
   endtask

   task automatic drain(input int budget);
      int n;
      m_ready = 1'b1;
      n = 0;
      while (count != '0 && n < budget) begin
         tick();
         n++;
      end
      @(negedge clk);
      check("drain_count", count, 0);
   endtask

   // ---------------- classification table ----------------
   typedef struct {
      logic [31:0] instr;
      logic        exp_ill;
      logic        exp_mv;
      logic [2:0]  exp_cnt;
   } vec_t;

   vec_t tbl[9];

   // ---------------- test sequence ----------------
   logic [31:0] vsetvli_w;
   logic [31:0] vadd_w;

   initial begin
      tbl[0] = '{mk(OPC_RTYPE, OPI_VV, 8'h01), 1'b0, 1'b1, 3'd1};
      tbl[1] = '{mk(OPC_LTYPE, W32,    8'h02), 1'b0, 1'b1, 3'd1};
      tbl[2] = '{mk(OPC_STYPE, W32,    8'h03), 1'b0, 1'b1, 3'd1};
      tbl[3] = '{mk(OPC_RTYPE, OP_SET, 8'h04), 1'b0, 1'b1, 3'd1};
      tbl[4] = '{32'h0020_80b3,               1'b1, 1'b0, 3'd0}; // add (0x33)
      tbl[5] = '{32'h0010_0093,               1'b1, 1'b0, 3'd0}; // addi (0x13)
      tbl[6] = '{32'h0000_2083,               1'b1, 1'b0, 3'd0}; // lw (0x03)
      tbl[7] = '{32'h0000_006f,               1'b1, 1'b0, 3'd0}; // jal (0x6f)
      tbl[8] = '{mk(OPC_RTYPE, OPI_VV, 8'h09), 1'b0, 1'b1, 3'd1};

      // reset
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_count", count, 0);
      check("reset_m_valid", m_valid, 1'b0);
      check("reset_illegal", illegal, 1'b0);
      check("reset_state", dut.state, ST_RUN);
      check("reset_s_ready", s_ready, 1'b1);
      tick();

      // table: one offer, then look at the cycle after acceptance
      m_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         push_one(tbl[i].instr, $urandom, $urandom);
         @(negedge clk);
         check("tbl_illegal", illegal, tbl[i].exp_ill);
         check("tbl_m_valid", m_valid, tbl[i].exp_mv);
         check("tbl_count", count, tbl[i].exp_cnt);
         tick();
      end
      drain(10);

      // 1: three vadds issue in order, each one cycle after push
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push_one(mk(OPC_RTYPE, OPI_VV, 8'h10 + 8'(i)), $urandom, $urandom);
         @(negedge clk);
         check("t1_m_valid", m_valid, 1'b1);
         tick();
      end
      @(negedge clk);
      check("t1_count", count, 0);
      tick();

      // 2: fill, hold fifth offer, single pop frees a slot
      m_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         push_one(mk(OPC_RTYPE, OPI_VV, 8'h20 + 8'(i)), $urandom, $urandom);
      s_valid = 1'b1;
      s_instr = mk(OPC_LTYPE, W32, 8'h24);
      s_rs1   = $urandom;
      s_rs2   = $urandom;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t2_full_s_ready", s_ready, 1'b0);
         check("t2_full_count", count, 4);
         tick();
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      @(negedge clk);
      check("t2_s_ready_after_pop", s_ready, 1'b1);
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      check("t2_refill_count", count, 4);
      tick();
      drain(20);
      tick();

      // 3: vsetvli drains the datapath and blocks the younger vadd
      vsetvli_w = mk(OPC_RTYPE, OP_SET, 8'h31);
      vadd_w    = mk(OPC_RTYPE, OPI_VV, 8'h32);
      v_busy  = 1'b1;
      m_ready = 1'b1;
      push_one(mk(OPC_LTYPE, W32, 8'h30), 32'h0000_1000, 32'h0);
      push_one(vsetvli_w, 32'd17, 32'h0000_00d0);
      push_one(vadd_w, $urandom, $urandom);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_drain_m_valid", m_valid, 1'b0);
         check("t3_drain_state", dut.state, ST_DRAIN);
         check("t3_drain_count", count, 2);
         tick();
      end
      v_busy = 1'b0;
      @(negedge clk);
      check("t3_drain_exit_m_valid", m_valid, 1'b0);
      tick();
      @(negedge clk);
      check("t3_cfg_issue_valid", m_valid, 1'b1);
      check("t3_cfg_issue_instr", m_instr, vsetvli_w);
      tick();
      v_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_cfg_block_m_valid", m_valid, 1'b0);
         check("t3_cfg_state", dut.state, ST_CFG);
         tick();
      end
      v_busy = 1'b0;
      @(negedge clk);
      check("t3_cfg_last_m_valid", m_valid, 1'b0);
      tick();
      @(negedge clk);
      check("t3_vadd_valid", m_valid, 1'b1);
      check("t3_vadd_instr", m_instr, vadd_w);
      tick();
      @(negedge clk);
      check("t3_count", count, 0);
      tick();

      // 4: scalar opcode while entries are queued
      m_ready = 1'b0;
      push_one(mk(OPC_RTYPE, OPI_VV, 8'h40), $urandom, $urandom);
      push_one(32'h0020_80b3, $urandom, $urandom);
      @(negedge clk);
      check("t4_illegal", illegal, 1'b1);
      check("t4_count", count, 1);
      tick();
      @(negedge clk);
      check("t4_illegal_clear", illegal, 1'b0);
      tick();
      drain(10);
      tick();

      // 5: steady push+pop at count=2 with pointer wrap
      m_ready = 1'b0;
      push_one(mk(OPC_RTYPE, OPI_VV, 8'h50), $urandom, $urandom);
      push_one(mk(OPC_LTYPE, W32,    8'h51), $urandom, $urandom);
      m_ready = 1'b1;
      s_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s_instr = mk((i % 2 == 0) ? OPC_STYPE : OPC_RTYPE, OPI_VV, 8'h60 + 8'(i));
         s_rs1   = $urandom;
         s_rs2   = $urandom_range(0, 255);
         @(negedge clk);
         check("t5_count", count, 2);
         check("t5_m_valid", m_valid, 1'b1);
         tick();
      end
      s_valid = 1'b0;
      drain(10);
      tick();

      // 6a: flush with count=3 (FSM in DRAIN) and a push in the same cycle
      v_busy  = 1'b1;
      m_ready = 1'b0;
      push_one(mk(OPC_RTYPE, OP_SET, 8'h70), $urandom, $urandom);
      push_one(mk(OPC_RTYPE, OPI_VV, 8'h71), $urandom, $urandom);
      push_one(mk(OPC_RTYPE, OPI_VV, 8'h72), $urandom, $urandom);
      @(negedge clk);
      check("t6_pre_count", count, 3);
      check("t6_pre_state", dut.state, ST_DRAIN);
      tick();
      flush   = 1'b1;
      s_valid = 1'b1;
      s_instr = mk(OPC_RTYPE, OPI_VV, 8'h73);
      tick();
      flush   = 1'b0;
      s_valid = 1'b0;
      v_busy  = 1'b0;
      @(negedge clk);
      check("t6_flush_count", count, 0);
      check("t6_flush_m_valid", m_valid, 1'b0);
      check("t6_flush_state", dut.state, ST_RUN);
      tick();

      // 6b: reset mid-stream
      push_one(mk(OPC_RTYPE, OPI_VV, 8'h80), $urandom, $urandom);
      push_one(mk(OPC_LTYPE, W32,    8'h81), $urandom, $urandom);
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("t6_rst_s_ready", s_ready, 1'b0);
         check("t6_rst_m_valid", m_valid, 1'b0);
         tick();
      end
      rst = 1'b0;
      @(negedge clk);
      check("t6_rst_count", count, 0);
      check("t6_rst_m_valid_after", m_valid, 1'b0);
      check("t6_rst_state", dut.state, ST_RUN);
      check("t6_rst_illegal", illegal, 1'b0);
      tick();

      // normal operation after reset
      m_ready = 1'b1;
      push_one(mk(OPC_STYPE, W32, 8'h90), 32'h0000_2000, 32'd4);
      @(negedge clk);
      check("post_rst_m_valid", m_valid, 1'b1);
      tick();
      drain(10);

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
